// File: rtl/mux_nto1_reg_pkg.sv
// Shared constants and helpers for the registered N-to-1 operand selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_nto1_reg_pkg;

    // Selection mode encodings for the mode input.
    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Bits needed to index n channels; at least one bit even for n <= 2.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_reg_arb.sv
// Rotate-priority arbiter: grants the first requester after ptr, modulo NCH.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller gates the grant with its own load condition.
module rr_arbiter_n #(
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    // Walk candidates from farthest to nearest so the nearest requester after ptr wins last.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        for (int k = NCH; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NCH;
            if (req[idx]) begin
                gnt_idx   = SEL_W'(idx);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 channel selector, fixed-index or round-robin, feeding the ALU operand path.
// Latency: one cycle from input transfer to out_valid; one word per cycle at full throughput.
// Backpressure: output stage holds while out_valid & !out_ready; all in_ready drop during a stall.
module mux_nto1_reg
    import mux_nto1_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SEL_W = idx_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int NPAD = 2 ** SEL_W;

    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic [SEL_W-1:0]      out_ch_q, out_ch_d;
    logic                  out_valid_q, out_valid_d;
    logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

    // Padded copies so every sel value indexes a defined bit/word; pad channels never request.
    logic [NPAD-1:0]       valid_ext;
    logic [NPAD*WIDTH-1:0] data_ext;

    logic                  fix_vld;
    logic [SEL_W-1:0]      rr_idx;
    logic                  rr_vld;
    logic [SEL_W-1:0]      gnt_idx;
    logic                  gnt_vld;
    logic                  can_load;
    logic                  load;
    logic [WIDTH-1:0]      sel_word;

    rr_arbiter_n #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr_q),
        .gnt_idx   (rr_idx),
        .gnt_valid (rr_vld)
    );

    // Zero-extend channel vectors; an out-of-range sel lands on a pad channel and never grants.
    always_comb begin
        valid_ext                  = '0;
        valid_ext[NCH-1:0]         = in_valid;
        data_ext                   = '0;
        data_ext[NCH*WIDTH-1:0]    = in_data;
        fix_vld                    = valid_ext[sel];
    end

    // Pick the grant source by mode and derive the load/handshake; reset suppresses any ready.
    always_comb begin
        if (mode == MODE_RR) begin
            gnt_idx = rr_idx;
            gnt_vld = rr_vld;
        end else begin
            gnt_idx = sel;
            gnt_vld = fix_vld;
        end
        can_load = !out_valid_q || out_ready;
        load     = rst && can_load && gnt_vld;
        sel_word = data_ext[int'(gnt_idx)*WIDTH +: WIDTH];
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            in_ready[i] = load && (gnt_idx == SEL_W'(i));
        end
    end

    // Next state of the output stage: load (possibly over a draining word), drain, or hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            out_data_d  = sel_word;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                rr_ptr_d = gnt_idx;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and round-robin pointer; pointer resets so the first search starts at ch0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= SEL_W'(NCH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
